// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit with tag, flush and valid/ready.
// Optional MULDIV_FAST_MUL_EN replaces the shift-add multiply with a single-step product.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [1:0]       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and payload (result/out_tag) is stable while valid waits.
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            op_sel;
    logic                  neg_q, neg_r, special;
    logic [XLEN-1:0]       mcand;
    logic [2*XLEN-1:0]     acc;

    logic                  accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic                  div_zero, div_ovf, last;
    logic [XLEN-1:0]       mag_a, mag_b, special_val;
    logic [XLEN:0]         div_tmp, div_diff;
    logic [2*XLEN-1:0]     acc_nxt, prod_fix;
    logic [XLEN-1:0]       quo_fix, rem_fix, final_val;

    assign accept = in_valid && in_ready;

    always_comb begin
        is_div      = funct3[2];
        a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg       = a_signed && rs1_val[XLEN-1];
        b_neg       = b_signed && rs2_val[XLEN-1];
        mag_a       = a_neg ? -rs1_val : rs1_val;
        mag_b       = b_neg ? -rs2_val : rs2_val;
        div_zero    = is_div && (rs2_val == '0);
        div_ovf     = is_div && !funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        special_val = '0;
        if (div_zero) special_val = funct3[1] ? rs1_val : '1;
        else          special_val = funct3[1] ? '0 : rs1_val;
    end

    // One iteration step; the final value is resolved from the post-step accumulator
    // so the result register is loaded on the same edge that enters DONE.
`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_tmp - {1'b0, mcand};
        acc_nxt  = acc;
        last     = (state == S_MUL) || (cnt == CNT_W'(XLEN-1));
        if (state == S_MUL)
            acc_nxt = (2*XLEN)'(mcand) * (2*XLEN)'(acc[XLEN-1:0]);
        else if (state == S_DIV)
            acc_nxt = div_diff[XLEN] ? {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
`else
    logic [XLEN:0] mul_sum;
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_tmp - {1'b0, mcand};
        acc_nxt  = acc;
        last     = (cnt == CNT_W'(XLEN-1));
        if (state == S_MUL)
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        else if (state == S_DIV)
            acc_nxt = div_diff[XLEN] ? {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
`endif

    always_comb begin
        prod_fix  = neg_q ? -acc_nxt : acc_nxt;
        quo_fix   = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix   = neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        final_val = '0;
        if (special)
            final_val = acc[XLEN-1:0];
        else if (state == S_MUL)
            final_val = (op_sel == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            final_val = op_sel[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (accept) state_nxt = is_div ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (special || last) state_nxt = S_DONE;
            S_DONE:       if (out_ready) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !flush;
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        dbg_state = state;
    end

    // Divide keeps {remainder, dividend/quotient} in acc; multiply keeps {partial, multiplier}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_sel  <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
            mcand   <= '0;
            acc     <= '0;
            result  <= '0;
            out_tag <= '0;
        end else if (accept) begin
            cnt     <= '0;
            op_sel  <= funct3[1:0];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            special <= div_zero || div_ovf;
            out_tag <= in_tag;
            mcand   <= is_div ? mag_b : mag_a;
            if (div_zero || div_ovf) acc <= {{XLEN{1'b0}}, special_val};
            else                     acc <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
        end else if ((state == S_MUL || state == S_DIV) && !flush) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (special || last) result <= final_val;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (XLEN=32); honours MULDIV_FAST_MUL_EN
// for the expected multiply latency.
module tb_ex_muldiv_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       funct3 = 3'b000;
    logic [XLEN-1:0]  rs1_val = '0;
    logic [XLEN-1:0]  rs2_val = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_tag(out_tag), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Drive one request, scramble the inputs after acceptance, wait for the result, then take it.
    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] t);
        @(negedge clk);
        funct3 = f; rs1_val = a; rs2_val = b; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1_val = $urandom; rs2_val = $urandom; in_tag = TAG_W'($urandom_range(0, 31));
        funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] t, output logic [XLEN-1:0] r,
                          output logic [TAG_W-1:0] rt, output int lat);
        issue(f, a, b, t);
        wait_valid(lat);
        r  = result;
        rt = out_tag;
        take_result();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({out_valid, busy, in_ready, dbg_state} !== {1'b0, 1'b0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL reset_ctrl: got v=%b b=%b r=%b s=%0d want v=0 b=0 r=1 s=0",
                     out_valid, busy, in_ready, dbg_state);
        end
        checks++;
        if ({result, out_tag} !== {32'h0, 5'd0}) begin
            errors++;
            $display("FAIL reset_data: got result=%h tag=%0d want 0/0", result, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [2:0]      fv [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 3'b011};
        logic [XLEN-1:0] av [6] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000};
        logic [XLEN-1:0] bv [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'h00010000};
        logic [XLEN-1:0] ev [6] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] rt;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(fv[i], av[i], bv[i], TAG_W'(i + 5), r, rt, lat);
            checks++;
            if (r !== ev[i]) begin
                errors++;
                $display("FAIL mul_result[%0d]: got %h want %h", i, r, ev[i]);
            end
            checks++;
            if (rt !== TAG_W'(i + 5)) begin
                errors++;
                $display("FAIL mul_tag[%0d]: got %0d want %0d", i, rt, i + 5);
            end
            checks++;
            if (lat != MUL_LAT) begin
                errors++;
                $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, MUL_LAT);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]      fv [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [XLEN-1:0] av [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
        logic [XLEN-1:0] bv [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [XLEN-1:0] ev [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1, 32'd0, 32'h80000000};
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] rt;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(fv[i], av[i], bv[i], TAG_W'(3 * i + 1), r, rt, lat);
            checks++;
            if (r !== ev[i] || rt !== TAG_W'(3 * i + 1)) begin
                errors++;
                $display("FAIL div_result[%0d]: got %h tag %0d want %h tag %0d", i, r, rt, ev[i], 3 * i + 1);
            end
            checks++;
            if (lat != XLEN) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, XLEN);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]      fv [6] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b110, 3'b101};
        logic [XLEN-1:0] av [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
        logic [XLEN-1:0] bv [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [XLEN-1:0] ev [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd5, 32'hFFFFFFFF};
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] rt;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(fv[i], av[i], bv[i], TAG_W'(20 + i), r, rt, lat);
            checks++;
            if (r !== ev[i] || rt !== TAG_W'(20 + i)) begin
                errors++;
                $display("FAIL div_special[%0d]: got %h tag %0d want %h tag %0d", i, r, rt, ev[i], 20 + i);
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL special_latency[%0d]: got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(3'b101, 32'd100, 32'd7, 5'd9);
        wait_valid(lat);
        checks++;
        if (lat != XLEN) begin
            errors++;
            $display("FAIL bp_latency: got %0d want %0d", lat, XLEN);
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({result, out_tag, in_ready, busy, out_valid} !== {32'd14, 5'd9, 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got result=%h tag=%0d rdy=%b busy=%b v=%b want 0000000e/9/0/1/1",
                         c, result, out_tag, in_ready, busy, out_valid);
            end
            @(posedge clk); #1;
        end
        take_result();
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_flush();
        int seen;
        int lat;
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] rt;
        issue(3'b100, 32'd1000, 32'd3, 5'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if ({busy, out_valid, dbg_state} !== {1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL flush_div: got busy=%b v=%b state=%0d want 0/0/0", busy, out_valid, dbg_state);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_result: got %0d valid cycles want 0", seen);
        end
        // A request arriving together with flush must not be taken.
        @(negedge clk);
        funct3 = 3'b101; rs1_val = 32'd9; rs2_val = 32'd2; in_valid = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_accept: got busy=%b want 0", busy);
        end
        // Flush of a finished result that is still waiting for the consumer.
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17);
        wait_valid(lat);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if ({out_valid, busy} !== 2'b00 || lat != MUL_LAT) begin
            errors++;
            $display("FAIL flush_done: got v=%b busy=%b lat=%0d want 0/0/%0d", out_valid, busy, lat, MUL_LAT);
        end
        run_op(3'b101, 32'd100, 32'd7, 5'd12, r, rt, lat);
        checks++;
        if (r !== 32'd14 || rt !== 5'd12 || lat != XLEN) begin
            errors++;
            $display("FAIL flush_recover: got %h tag %0d lat %0d want 0000000e tag 12 lat %0d", r, rt, lat, XLEN);
        end
    endtask

    task automatic test_async_reset();
        logic [XLEN-1:0] r;
        logic [TAG_W-1:0] rt;
        int lat;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, r, rt, lat);
        checks++;
        if (r !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL pre_reset_mul: got %h want ffffffeb", r);
        end
        issue(3'b000, 32'd3, 32'd4, 5'd11);
        if (MUL_LAT > 1) repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, result, out_tag} !== {1'b0, 1'b0, 32'h0, 5'd0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b busy=%b result=%h tag=%0d want 0/0/0/0",
                     out_valid, busy, result, out_tag);
        end
        #2;
        rst_n = 1'b1;
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd30, r, rt, lat);
        checks++;
        if (r !== 32'hFFFFFFFE || rt !== 5'd30 || lat != MUL_LAT) begin
            errors++;
            $display("FAIL post_reset_mul: got %h tag %0d lat %0d want fffffffe tag 30 lat %0d", r, rt, lat, MUL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M/RV64M multiply/divide execute unit, parametrised in XLEN.
- Sits beside the combinational ALU in the execute stage and receives the OP-opcode instructions with funct7=0000001.
- Uses a valid/ready handshake on both input and output, carries a destination tag, and supports pipeline flush.
- Iterative radix-2 datapath with a state machine; results conform to the RISC-V M spec, including divide corner cases.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and even.
- TAG_W, 5, width of the destination-register tag carried with the operation.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of any in-flight or pending operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  XLEN  dividend / multiplicand.
- rs2_val  in  XLEN  divisor / multiplier.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, result=0, out_tag=0, busy=0, iteration counter=0. in_ready follows its combinational equation below.
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE) && !flush. Accept = in_valid && in_ready at a rising edge ("edge 0"). Operands, funct3 and tag are latched at edge 0; later changes on the inputs are ignored.
- Signed handling: operands are converted to magnitudes per op signedness:
  - MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. DIV/REM: both signed. MUL: sign irrelevant.
  - The result is negated at completion if required.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- MUL path: shift-add over the full 2*XLEN product, one bit per edge, edges 1..XLEN. DONE is entered at edge XLEN. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DIV path: restoring division, one quotient bit per edge, edges 1..XLEN, then DONE. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide special cases, detected at edge 0; the unit goes straight to DONE at edge 1:
  - Divisor zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1, DIV/REM only): quotient = rs1; remainder = 0.
- DONE: out_valid=1, with result and out_tag stable until the handshake. On out_valid && out_ready the unit returns to IDLE at that edge and out_valid falls; in_ready is high in the following cycle. There is no same-cycle back-to-back accept.
- Latency, accept edge to the first cycle out_valid is high: XLEN cycles for normal MUL/DIV; 1 cycle for special cases.
- flush: at the next edge state→IDLE and out_valid→0, from any state including DONE. A pending result is discarded and no handshake occurs. Flush overrides a simultaneous accept (in_ready is low while flush=1) and a simultaneous out_ready.
- rst_n asserted mid-operation: immediate return to the reset state; no result is produced.
- Arithmetic is modulo 2^XLEN. The internal accumulator is 2*XLEN wide (mul) or XLEN+1 wide (div partial remainder).

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- When defined: the MUL path computes the full product in one step at edge 1 with a single-cycle multiplier, so MUL-family latency is 1 cycle. The DIV path is unchanged.
- When undefined: iterative shift-add multiply with XLEN-cycle latency, as above. All results are identical in both builds.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), tag=5 → result 0xFFFFFFEB, out_tag=5, out_valid first high 32 cycles after accept (1 cycle with MULDIV_FAST_MUL_EN).
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with 1-cycle latency. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result/out_tag stable, in_ready=0, busy=1. Raise out_ready → out_valid falls next edge and in_ready is high the cycle after handshake.
- Flush after 10 DIV iterations → IDLE next edge, no out_valid ever. Separately, pulse rst_n low mid-MUL → outputs zero immediately, next op completes correctly.
